// File: rtl/alu_unit_if.sv
// Issue/broadcast bundle between the reservation station and the ALU.
// The master issues instructions; the slave (ALU) drives busy and the CDB slot.
interface alu_unit_if #(
    parameter int TYPE_W = 5,
    parameter int ROB_W  = 4
);
    logic              alu_input;
    logic [TYPE_W-1:0] arith_type;
    logic [31:0]       alu_r1_val;
    logic [31:0]       alu_r2_val;
    logic [ROB_W-1:0]  inst_rob_id;
    logic              alu_busy;
    logic              rs_fi;
    logic [31:0]       rs_value;
    logic [ROB_W-1:0]  rs_rob_id;

    modport master (
        output alu_input, arith_type, alu_r1_val, alu_r2_val, inst_rob_id,
        input  alu_busy, rs_fi, rs_value, rs_rob_id
    );

    modport slave (
        input  alu_input, arith_type, alu_r1_val, alu_r2_val, inst_rob_id,
        output alu_busy, rs_fi, rs_value, rs_rob_id
    );
endinterface

// File: rtl/alu_unit.sv
// RV32IM execution unit: single-cycle ALU/compare, two-cycle multiply and a
// 32-step restoring divider, all broadcasting on one CDB slot.
module alu_unit #(
    parameter int TYPE_W = 5,
    parameter int ROB_W  = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    input  logic       rob_clear,
    alu_unit_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_fi;
    logic [31:0]       r_value;
    logic [ROB_W-1:0]  r_rob;
    logic [ROB_W-1:0]  r_id;
    logic [5:0]        r_cnt;
    // Multiply: raw operands. Divide: r_opa is dividend/quotient shifter, r_opb divisor.
    logic [31:0]       r_opa;
    logic [31:0]       r_opb;
    logic [31:0]       r_rem;
    logic              r_sgn_a;
    logic              r_sgn_b;
    logic [1:0]        r_kind;

    logic [TYPE_W-1:0] w_type;
    logic [31:0]       w_op;
    logic [31:0]       w_a;
    logic [31:0]       w_b;
    logic              w_accept;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_div_uns;
    logic              w_div_rem;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_div_spec;
    logic [31:0]       w_spec_val;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [31:0]       w_a_abs;
    logic [31:0]       w_b_abs;
    logic [31:0]       w_simple;
    logic [63:0]       w_ma64;
    logic [63:0]       w_mb64;
    logic [63:0]       w_prod;
    logic [31:0]       w_mul_res;
    logic [32:0]       w_shift;
    logic [32:0]       w_diff;
    logic              w_ge;
    logic [31:0]       w_quo;
    logic [31:0]       w_rmd;
    logic [31:0]       w_div_res;

    assign w_type   = bus.arith_type;
    assign w_op     = 32'(w_type);
    assign w_a      = bus.alu_r1_val;
    assign w_b      = bus.alu_r2_val;
    assign w_accept = rdy_in && !rob_clear && (r_state == S_IDLE) && bus.alu_input;

    assign w_is_mul   = (w_op >= 32'd16) && (w_op <= 32'd19);
    assign w_is_div   = (w_op >= 32'd20) && (w_op <= 32'd23);
    assign w_div_uns  = w_op[0];
    assign w_div_rem  = w_op[1];
    assign w_div_zero = (w_b == 32'd0);
    assign w_div_ovf  = !w_div_uns && (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF);
    assign w_div_spec = w_div_zero || w_div_ovf;
    assign w_spec_val = w_div_zero ? (w_div_rem ? w_a : 32'hFFFF_FFFF)
                                   : (w_div_rem ? 32'd0 : 32'h8000_0000);

    assign w_a_neg = !w_div_uns && w_a[31];
    assign w_b_neg = !w_div_uns && w_b[31];
    assign w_a_abs = w_a_neg ? (32'd0 - w_a) : w_a;
    assign w_b_abs = w_b_neg ? (32'd0 - w_b) : w_b;

    // Sign-extending to 64 bits keeps every signedness combination exact mod 2^64.
    assign w_ma64    = {{32{r_sgn_a & r_opa[31]}}, r_opa};
    assign w_mb64    = {{32{r_sgn_b & r_opb[31]}}, r_opb};
    assign w_prod    = w_ma64 * w_mb64;
    assign w_mul_res = (r_kind == 2'b00) ? w_prod[31:0] : w_prod[63:32];

    // Remainder stays below the divisor, so bit 32 of the difference is the borrow.
    assign w_shift   = {r_rem, r_opa[31]};
    assign w_diff    = w_shift - {1'b0, r_opb};
    assign w_ge      = !w_diff[32];
    assign w_quo     = r_sgn_a ? (32'd0 - r_opa) : r_opa;
    assign w_rmd     = r_sgn_b ? (32'd0 - r_rem) : r_rem;
    assign w_div_res = r_kind[1] ? w_rmd : w_quo;

    always_comb begin
        // NOTE: default first so no path through the case can infer a latch.
        w_simple = 32'd0;
        case (w_op)
            32'd0:  w_simple = w_a + w_b;
            32'd1:  w_simple = w_a - w_b;
            32'd2:  w_simple = w_a << w_b[4:0];
            32'd3:  w_simple = {31'd0, $signed(w_a) < $signed(w_b)};
            32'd4:  w_simple = {31'd0, w_a < w_b};
            32'd5:  w_simple = w_a ^ w_b;
            32'd6:  w_simple = w_a >> w_b[4:0];
            32'd7:  w_simple = $signed(w_a) >>> w_b[4:0];
            32'd8:  w_simple = w_a | w_b;
            32'd9:  w_simple = w_a & w_b;
            32'd10: w_simple = {31'd0, w_a == w_b};
            32'd11: w_simple = {31'd0, w_a != w_b};
            32'd12: w_simple = {31'd0, $signed(w_a) < $signed(w_b)};
            32'd13: w_simple = {31'd0, $signed(w_a) >= $signed(w_b)};
            32'd14: w_simple = {31'd0, w_a < w_b};
            32'd15: w_simple = {31'd0, w_a >= w_b};
            default: w_simple = 32'd0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (w_is_mul)                    w_next = S_MUL;
                else if (w_is_div && !w_div_spec) w_next = S_DIV;
            end
            S_MUL:  w_next = S_IDLE;
            S_DIV:  if (r_cnt == 6'd31) w_next = S_FIN;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (rob_clear) w_next = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (!rst_in)     r_state <= S_IDLE;
        else if (rdy_in) r_state <= w_next;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_fi    <= 1'b0;
            r_value <= 32'd0;
            r_rob   <= '0;
            r_id    <= '0;
            r_cnt   <= 6'd0;
            r_opa   <= 32'd0;
            r_opb   <= 32'd0;
            r_rem   <= 32'd0;
            r_sgn_a <= 1'b0;
            r_sgn_b <= 1'b0;
            r_kind  <= 2'b00;
        end else if (rdy_in) begin
            r_fi <= 1'b0;
            if (!rob_clear) begin
                case (r_state)
                    S_IDLE: if (bus.alu_input) begin
                        r_id   <= bus.inst_rob_id;
                        r_kind <= w_op[1:0];
                        if (w_is_mul) begin
                            r_opa   <= w_a;
                            r_opb   <= w_b;
                            r_sgn_a <= (w_op[1:0] == 2'b01) || (w_op[1:0] == 2'b10);
                            r_sgn_b <= (w_op[1:0] == 2'b01);
                        end else if (w_is_div && !w_div_spec) begin
                            r_opa   <= w_a_abs;
                            r_opb   <= w_b_abs;
                            r_rem   <= 32'd0;
                            r_cnt   <= 6'd0;
                            r_sgn_a <= w_a_neg ^ w_b_neg;
                            r_sgn_b <= w_a_neg;
                        end else begin
                            r_fi    <= 1'b1;
                            r_rob   <= bus.inst_rob_id;
                            r_value <= w_is_div ? w_spec_val : w_simple;
                        end
                    end
                    S_MUL: begin
                        r_fi    <= 1'b1;
                        r_rob   <= r_id;
                        r_value <= w_mul_res;
                    end
                    S_DIV: begin
                        r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
                        r_opa <= {r_opa[30:0], w_ge};
                        r_cnt <= r_cnt + 6'd1;
                    end
                    S_FIN: begin
                        r_fi    <= 1'b1;
                        r_rob   <= r_id;
                        r_value <= w_div_res;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.alu_busy  = (r_state != S_IDLE);
    assign bus.rs_fi     = r_fi;
    assign bus.rs_value  = r_value;
    assign bus.rs_rob_id = r_rob;
endmodule
